qspi_nor_emu: RTL and testbench
===============================

# qspi_nor_emu

Clocked, parametrised SPI/QPI NOR flash responder used in the simulation top, and usable as an emulation target, in place of the untimed 1-1-1 and 4-4-4 flash models. It oversamples the flash pins on the system clock and serves reads from a byte array loaded through a backdoor port. One instance handles both wire modes: standard SPI (1-1-1) and QPI (4-4-4), switched at run time by enter/exit commands.

## Interface

- DEPTH_LOG2, 9: array holds 2^DEPTH_LOG2 bytes.
- DUMMY_SPI, 8: dummy sck cycles for fast read (0x0B) in SPI mode.
- DUMMY_QPI, 10: dummy sck cycles for fast read (0x0B) in QPI mode.
- clk  in  1  system clock; must run at 8x sck or faster.
- rstn  in  1  asynchronous, active-low reset.
- sck  in  1  flash serial clock from host.
- csb  in  1  flash chip select, active low.
- sio_i  in  4  flash data pins, input side.
- sio_o  out  4  flash data pins, output side.
- sio_oe  out  4  per-pin output enable.
- qpi_mode  out  1  1 = device in QPI (4-4-4) mode.
- busy  out  1  state != IDLE.
- init_we  in  1  backdoor byte write strobe.
- init_addr  in  DEPTH_LOG2  backdoor address.
- init_data  in  8  backdoor data.

## Operation

- sck, csb and sio_i each pass through a 2-flop synchroniser. A third flop on sck gives rise/fall detect pulses, each one clk wide.
- States: IDLE, CMD, ADDR, DUMMY, DATA, DISCARD.
- IDLE -> CMD on synchronised csb = 0. The bit counter is cleared.
- CMD shifts 8 bits on sck rises: sio_i[0] per rise in SPI mode, a nibble (high first) per rise in QPI mode.
- Command decode runs on the final CMD rise:
  - 0x03 read: go to ADDR, dummy count 0.
  - 0x0B fast read: go to ADDR, dummy count = DUMMY_SPI or DUMMY_QPI depending on mode.
  - 0x38 enter QPI: valid in SPI mode only. qpi_mode is set at csb rise; go to DISCARD.
  - 0xFF exit QPI: valid in QPI mode only. qpi_mode is cleared at csb rise; go to DISCARD.
  - Any other code, or 0x38/0xFF in the wrong mode: go to DISCARD with no effect.
- ADDR shifts 24 bits MSB first, at the same lane width as CMD. After the last rise, go to DUMMY if the dummy count is nonzero, otherwise to DATA.
- DUMMY counts sck rises down to 0, then goes to DATA.
- DATA output on each sck fall:
  - SPI mode: sio_o[1] = current bit, MSB first; sio_oe = 4'b0010.
  - QPI mode: sio_o = current nibble, high nibble first; sio_oe = 4'hF.
  - sio_oe asserts together with the first sio_o update.
- Address use: only addr[DEPTH_LOG2-1:0] indexes the array. It increments after each full byte and wraps from 2^DEPTH_LOG2-1 to 0. Reads continue indefinitely.
- DISCARD ignores sck until csb rises.
- Synchronised csb rise, from any state:
  - Next clk: state = IDLE, sio_oe = 0, pending qpi_mode change applied.
  - A partial command or address is dropped.
  - Mode changes only if the full 8-bit command was received.
- Backdoor writes: a write on init_we happens on that clk in any state. The current output byte is latched when the byte starts, so a same-cycle write to the byte being read shows up only on the next visit to that address.
- qpi_mode persists across transactions. Only a valid 0xFF command or a reset clears it.

## Timing

- Reset values: sio_o = 0, sio_oe = 0, qpi_mode = 0, busy = 0, state = IDLE, counters = 0, synchroniser flops = idle (csb = 1, sck = 0). The array is not reset.
- Input sample latency: 3 clk from a pin edge to the rise/fall pulse.
- Output latency: sio_o/sio_oe are registered and valid 4 clk after the sck fall at the pin. Host must sample on the next sck rise.
- busy rises 3 clk after csb falls and drops 4 clk after csb rises.
- Back-to-back transactions need csb high for at least 4 clk.

## Configuration

- QSPI_NOR_EMU_QPI_EN defined: QPI mode, commands 0x38/0xFF, and DUMMY_QPI are compiled in.
- Not defined:
  - qpi_mode is tied to 0.
  - 0x38 and 0xFF decode as unknown and go to DISCARD.
  - sio_oe[3:2] and sio_oe[0] are constant 0.

## Test plan

- SPI 0x03 read: preload 0x000..0x003 = 11 22 33 44; send 0x03, addr 0x000000, clock 32 data bits -> sio_o[1] serialises 11 22 33 44, sio_oe = 0010.
- SPI 0x0B: send addr 0x000002, 8 dummy, 16 data -> 33 44; sio_oe stays 0 through the dummy cycles.
- Wrap: DEPTH_LOG2 = 9, read from 0x0001FF for 2 bytes -> array[0x1FF], then array[0x000].
- QPI (macro on): send 0x38, csb high -> qpi_mode = 1. Then quad 0x0B, addr 0x000000, 10 dummy, 4 nibbles -> 1,1,2,2 with sio_oe = F. Then 0xFF -> qpi_mode = 0.
- Abort: raise csb after 4 address bits -> busy = 0 and sio_oe = 0 within 4 clk. A following 0x03 read from 0x000001 returns 22.
- Reset mid-DATA: pull rstn low during byte 2 -> all outputs 0 and qpi_mode = 0 immediately. Array contents are retained.

Source files
------------

// File: rtl/qspi_nor_emu.sv
// qspi_nor_emu: clocked SPI/QPI NOR flash responder serving reads from a backdoor-loaded array.
// Define QSPI_NOR_EMU_QPI_EN to compile in QPI (4-4-4) mode, commands 0x38/0xFF and DUMMY_QPI.
module qspi_nor_emu #(
    parameter int DEPTH_LOG2 = 9,
    parameter int DUMMY_SPI  = 8,
    parameter int DUMMY_QPI  = 10
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  sck,
    input  logic                  csb,
    input  logic [3:0]            sio_i,
    output logic [3:0]            sio_o,
    output logic [3:0]            sio_oe,
    output logic                  qpi_mode,
    output logic                  busy,
    input  logic                  init_we,
    input  logic [DEPTH_LOG2-1:0] init_addr,
    input  logic [7:0]            init_data
);

    localparam int DMAX = (DUMMY_SPI > DUMMY_QPI) ? DUMMY_SPI : DUMMY_QPI;
    localparam int DW   = (DMAX > 0) ? $clog2(DMAX + 1) : 1;

    typedef enum logic [2:0] {
        IDLE, CMD, ADDR, DUMMY, DATA, DISCARD
    } state_t;

    state_t                state;
    logic [7:0]            mem [2**DEPTH_LOG2];
    logic                  sck_s1, sck_s2, sck_s3;
    logic                  csb_s1, csb_s2, csb_s3;
    logic [3:0]            sio_s1, sio_s2;
    logic                  sck_rise, sck_fall, csb_rise;
    logic                  qpi;
    logic [4:0]            bit_cnt;
    logic [2:0]            out_cnt;
    logic [DW-1:0]         dummy_cnt;
    logic [DW-1:0]         dummy_load;
    logic [6:0]            cmd_sr;
    logic [7:0]            cmd_nx;
    logic [DEPTH_LOG2-1:0] addr;
    logic [DEPTH_LOG2-1:0] addr_nx;
    logic [7:0]            out_byte;
    logic [7:0]            src;
    logic                  cmd_last, addr_last, byte_last;

`ifdef QSPI_NOR_EMU_QPI_EN
    logic qpi_q;
    logic pend;
    logic pend_val;
    assign qpi = qpi_q;
`else
    assign qpi = 1'b0;
`endif

    assign qpi_mode = qpi;
    assign busy     = (state != IDLE);

    // Pin synchronisers plus registered one-clk edge pulses.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sck_s1   <= 1'b0;
            sck_s2   <= 1'b0;
            sck_s3   <= 1'b0;
            csb_s1   <= 1'b1;
            csb_s2   <= 1'b1;
            csb_s3   <= 1'b1;
            sio_s1   <= 4'h0;
            sio_s2   <= 4'h0;
            sck_rise <= 1'b0;
            sck_fall <= 1'b0;
            csb_rise <= 1'b0;
        end else begin
            sck_s1   <= sck;
            sck_s2   <= sck_s1;
            sck_s3   <= sck_s2;
            csb_s1   <= csb;
            csb_s2   <= csb_s1;
            csb_s3   <= csb_s2;
            sio_s1   <= sio_i;
            sio_s2   <= sio_s1;
            sck_rise <= sck_s2 & ~sck_s3;
            sck_fall <= ~sck_s2 & sck_s3;
            csb_rise <= csb_s2 & ~csb_s3;
        end
    end

    // Backdoor array load; the array itself is never reset.
    always_ff @(posedge clk) begin
        if (init_we)
            mem[init_addr] <= init_data;
    end

    // Shift-in values, end-of-field flags and the byte being serialised.
    always_comb begin
        cmd_nx     = qpi ? {cmd_sr[3:0], sio_s2} : {cmd_sr, sio_s2[0]};
        addr_nx    = qpi ? {addr[DEPTH_LOG2-5:0], sio_s2}
                         : {addr[DEPTH_LOG2-2:0], sio_s2[0]};
        cmd_last   = (bit_cnt == (qpi ? 5'd1 : 5'd7));
        addr_last  = (bit_cnt == (qpi ? 5'd5 : 5'd23));
        byte_last  = (out_cnt == (qpi ? 3'd1 : 3'd7));
        src        = (out_cnt == 3'd0) ? mem[addr] : out_byte;
`ifdef QSPI_NOR_EMU_QPI_EN
        dummy_load = qpi ? DW'(DUMMY_QPI) : DW'(DUMMY_SPI);
`else
        dummy_load = DW'(DUMMY_SPI);
`endif
    end

    // Transaction FSM; csb rise aborts from any state and commits mode changes.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            bit_cnt   <= 5'd0;
            out_cnt   <= 3'd0;
            dummy_cnt <= '0;
            cmd_sr    <= 7'd0;
            addr      <= '0;
            out_byte  <= 8'h00;
            sio_o     <= 4'h0;
            sio_oe    <= 4'h0;
`ifdef QSPI_NOR_EMU_QPI_EN
            qpi_q     <= 1'b0;
            pend      <= 1'b0;
            pend_val  <= 1'b0;
`endif
        end else if (csb_rise) begin
            state   <= IDLE;
            sio_oe  <= 4'h0;
            bit_cnt <= 5'd0;
            out_cnt <= 3'd0;
`ifdef QSPI_NOR_EMU_QPI_EN
            if (pend)
                qpi_q <= pend_val;
            pend    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (!csb_s2) begin
                        state   <= CMD;
                        bit_cnt <= 5'd0;
                        out_cnt <= 3'd0;
                    end
                end
                CMD: begin
                    if (sck_rise) begin
                        cmd_sr  <= cmd_nx[6:0];
                        bit_cnt <= bit_cnt + 5'd1;
                        if (cmd_last) begin
                            bit_cnt <= 5'd0;
                            state   <= DISCARD;
                            case (cmd_nx)
                                8'h03: begin
                                    state     <= ADDR;
                                    dummy_cnt <= '0;
                                end
                                8'h0B: begin
                                    state     <= ADDR;
                                    dummy_cnt <= dummy_load;
                                end
`ifdef QSPI_NOR_EMU_QPI_EN
                                8'h38: begin
                                    if (!qpi) begin
                                        pend     <= 1'b1;
                                        pend_val <= 1'b1;
                                    end
                                end
                                8'hFF: begin
                                    if (qpi) begin
                                        pend     <= 1'b1;
                                        pend_val <= 1'b0;
                                    end
                                end
`endif
                                default: ;
                            endcase
                        end
                    end
                end
                ADDR: begin
                    if (sck_rise) begin
                        addr    <= addr_nx;
                        bit_cnt <= bit_cnt + 5'd1;
                        if (addr_last) begin
                            bit_cnt <= 5'd0;
                            out_cnt <= 3'd0;
                            state   <= (dummy_cnt != '0) ? DUMMY : DATA;
                        end
                    end
                end
                DUMMY: begin
                    if (sck_rise) begin
                        dummy_cnt <= dummy_cnt - DW'(1);
                        if (dummy_cnt <= DW'(1))
                            state <= DATA;
                    end
                end
                DATA: begin
                    if (sck_fall) begin
                        if (out_cnt == 3'd0) begin
                            out_byte <= mem[addr];
                            addr     <= addr + DEPTH_LOG2'(1);
                        end
                        if (qpi) begin
                            sio_o  <= out_cnt[0] ? src[3:0] : src[7:4];
                            sio_oe <= 4'hF;
                        end else begin
                            sio_o  <= {2'b00, src[3'd7 - out_cnt], 1'b0};
                            sio_oe <= 4'b0010;
                        end
                        out_cnt <= byte_last ? 3'd0 : out_cnt + 3'd1;
                    end
                end
                DISCARD: ;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_qspi_nor_emu.sv
// tb_qspi_nor_emu: directed host-side transactions against qspi_nor_emu.
// Drives sck at clk/8 on negedges and samples sio just before each sck rise.
module tb_qspi_nor_emu;

`ifdef QSPI_NOR_EMU_QPI_EN
    localparam bit QPI_EN = 1'b1;
`else
    localparam bit QPI_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       sck = 1'b0;
    logic       csb = 1'b1;
    logic [3:0] sio_i = 4'h0;
    logic [3:0] sio_o;
    logic [3:0] sio_oe;
    logic       qpi_mode;
    logic       busy;
    logic       init_we = 1'b0;
    logic [8:0] init_addr = 9'd0;
    logic [7:0] init_data = 8'h00;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [3:0]  smp_o;
    logic [3:0]  smp_oe;
    logic [31:0] rd_val;
    int          rd_oe_bad;
    logic [3:0]  oe_any;

    qspi_nor_emu #(
        .DEPTH_LOG2(9),
        .DUMMY_SPI (8),
        .DUMMY_QPI (10)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .sck      (sck),
        .csb      (csb),
        .sio_i    (sio_i),
        .sio_o    (sio_o),
        .sio_oe   (sio_oe),
        .qpi_mode (qpi_mode),
        .busy     (busy),
        .init_we  (init_we),
        .init_addr(init_addr),
        .init_data(init_data)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic mem_wr(input logic [8:0] a, input logic [7:0] d);
        @(negedge clk);
        init_we   = 1'b1;
        init_addr = a;
        init_data = d;
        @(negedge clk);
        init_we   = 1'b0;
    endtask

    task automatic sck_cyc(input logic [3:0] d);
        sio_i = d;
        repeat (4) @(negedge clk);
        smp_o  = sio_o;
        smp_oe = sio_oe;
        sck = 1'b1;
        repeat (4) @(negedge clk);
        sck = 1'b0;
    endtask

    task automatic cs_low();
        csb = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic cs_high();
        csb = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic spi_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--)
            sck_cyc({3'b000, b[i]});
    endtask

    task automatic spi_addr(input logic [23:0] a);
        for (int i = 23; i >= 0; i--)
            sck_cyc({3'b000, a[i]});
    endtask

    task automatic spi_read(input int nbits);
        rd_val    = 32'h0;
        rd_oe_bad = 0;
        for (int i = 0; i < nbits; i++) begin
            sck_cyc(4'h0);
            rd_val = {rd_val[30:0], smp_o[1]};
            if (smp_oe !== 4'b0010)
                rd_oe_bad++;
        end
    endtask

    task automatic idle_cycles(input int n);
        oe_any = 4'h0;
        for (int i = 0; i < n; i++) begin
            sck_cyc(4'h0);
            oe_any = oe_any | smp_oe;
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_sio_o", 32'(sio_o), 32'h0);
        check("rst_sio_oe", 32'(sio_oe), 32'h0);
        check("rst_qpi", 32'(qpi_mode), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        mem_wr(9'h000, 8'h11);
        mem_wr(9'h001, 8'h22);
        mem_wr(9'h002, 8'h33);
        mem_wr(9'h003, 8'h44);
        mem_wr(9'h1FF, 8'hA5);

        // SPI 0x03 from 0, with busy latency checks
        csb = 1'b0;
        repeat (2) @(negedge clk);
        check("busy_rise_early", 32'(busy), 32'h0);
        @(negedge clk);
        check("busy_rise", 32'(busy), 32'h1);
        @(negedge clk);
        spi_byte(8'h03);
        spi_addr(24'h000000);
        spi_read(32);
        check("rd03_data", rd_val, 32'h11223344);
        check("rd03_oe", 32'(rd_oe_bad), 32'h0);
        csb = 1'b1;
        repeat (3) @(negedge clk);
        check("busy_fall_early", 32'(busy), 32'h1);
        @(negedge clk);
        check("busy_fall", 32'(busy), 32'h0);
        check("oe_idle", 32'(sio_oe), 32'h0);
        repeat (4) @(negedge clk);

        // SPI 0x0B from 2 with 8 dummy cycles
        cs_low();
        spi_byte(8'h0B);
        spi_addr(24'h000002);
        idle_cycles(8);
        check("rd0b_dummy_oe", 32'(oe_any), 32'h0);
        spi_read(16);
        check("rd0b_data", rd_val, 32'h00003344);
        check("rd0b_oe", 32'(rd_oe_bad), 32'h0);
        cs_high();

        // wrap from the top of the array
        cs_low();
        spi_byte(8'h03);
        spi_addr(24'h0001FF);
        spi_read(16);
        check("wrap_data", rd_val, 32'h0000A511);
        cs_high();

        // upper address bits ignored
        cs_low();
        spi_byte(8'h03);
        spi_addr(24'hABCE01);
        spi_read(8);
        check("hiaddr_data", rd_val, 32'h00000022);
        cs_high();

        // unknown command is discarded
        cs_low();
        spi_byte(8'h9F);
        idle_cycles(8);
        check("unk_oe", 32'(oe_any), 32'h0);
        check("unk_busy", 32'(busy), 32'h1);
        cs_high();
        check("unk_qpi", 32'(qpi_mode), 32'h0);

        // enter QPI: takes effect only when built with QPI support
        cs_low();
        spi_byte(8'h38);
        check("enter_qpi_pending", 32'(qpi_mode), 32'h0);
        cs_high();
        check("enter_qpi", 32'(qpi_mode), 32'(QPI_EN));

`ifdef QSPI_NOR_EMU_QPI_EN
        cs_low();
        sck_cyc(4'h0);
        sck_cyc(4'hB);
        for (int i = 0; i < 6; i++)
            sck_cyc(4'h0);
        idle_cycles(10);
        check("qrd_dummy_oe", 32'(oe_any), 32'h0);
        rd_val    = 32'h0;
        rd_oe_bad = 0;
        for (int i = 0; i < 4; i++) begin
            sck_cyc(4'h0);
            rd_val = {rd_val[27:0], smp_o};
            if (smp_oe !== 4'hF)
                rd_oe_bad++;
        end
        check("qrd_data", rd_val, 32'h00001122);
        check("qrd_oe", 32'(rd_oe_bad), 32'h0);
        cs_high();
        check("qpi_persist", 32'(qpi_mode), 32'h1);
        cs_low();
        sck_cyc(4'hF);
        sck_cyc(4'hF);
        cs_high();
        check("exit_qpi", 32'(qpi_mode), 32'h0);
`endif

        // abort after 4 address bits
        cs_low();
        spi_byte(8'h03);
        for (int i = 0; i < 4; i++)
            sck_cyc(4'h0);
        csb = 1'b1;
        repeat (4) @(negedge clk);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_oe", 32'(sio_oe), 32'h0);
        repeat (4) @(negedge clk);
        cs_low();
        spi_byte(8'h03);
        spi_addr(24'h000001);
        spi_read(8);
        check("post_abort_data", rd_val, 32'h00000022);
        cs_high();

        // reset in the middle of byte 2
        cs_low();
        spi_byte(8'h03);
        spi_addr(24'h000000);
        spi_read(12);
        check("pre_rst_oe", 32'(sio_oe), 32'h2);
        rstn = 1'b0;
        #1;
        check("mid_rst_sio_o", 32'(sio_o), 32'h0);
        check("mid_rst_oe", 32'(sio_oe), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        check("mid_rst_qpi", 32'(qpi_mode), 32'h0);
        csb = 1'b1;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (4) @(negedge clk);
        cs_low();
        spi_byte(8'h03);
        spi_addr(24'h000000);
        spi_read(32);
        check("retain_data", rd_val, 32'h11223344);
        cs_high();

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
